// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: pulses each datapath unit in turn, owns the PC,
// retires instructions and faults when a unit never answers.
module stage_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255,
  parameter int unsigned       TO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              if_en,
  output logic              id_en,
  output logic              ex_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              br_en,
  output logic              ju_en,
  input  logic              if_done,
  input  logic              id_done,
  input  logic              ex_done,
  input  logic              mem_done,
  input  logic              wb_done,
  input  logic              br_done,
  input  logic              ju_done,
  input  logic              dec_jump,
  input  logic              dec_branch,
  input  logic              dec_mem_read,
  input  logic              dec_mem_write,
  input  logic              dec_reg_write,
  input  logic [ADDR_W-1:0] target_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [6:0]        stage,
  output logic              busy,
  output logic [31:0]       instr_count,
  output logic              fault
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_JU, ST_BR, ST_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              redir_q, redir_d;
  logic [31:0]       count_q, count_d;
  logic              fault_q, fault_d;
  logic              br_q, br_d, mrd_q, mrd_d, mwr_q, mwr_d, rw_q, rw_d;

  logic              unit_done, waiting, done_ok, retire, enter;
  state_e            enter_st;

  always_comb begin
    unit_done = 1'b0;
    waiting   = 1'b1;
    case (state_q)
      ST_IF:   unit_done = if_done;
      ST_ID:   unit_done = id_done;
      ST_EX:   unit_done = ex_done;
      ST_MEM:  unit_done = mem_done;
      ST_WB:   unit_done = wb_done;
      ST_JU:   unit_done = ju_done;
      ST_BR:   unit_done = br_done;
      default: waiting   = 1'b0;
    endcase
  end

  // A strobe on the entry cycle belongs to the previous request, so it is ignored.
  assign done_ok = waiting && !first_q && unit_done;

  always_comb begin
    state_d  = state_q;
    first_d  = 1'b0;
    wait_d   = wait_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    redir_d  = redir_q;
    count_d  = count_q;
    fault_d  = fault_q;
    br_d     = br_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    rw_d     = rw_q;
    retire   = 1'b0;
    enter    = 1'b0;
    enter_st = ST_IF;

    case (state_q)
      ST_IDLE: enter = run;
      ST_IF: begin
        if (done_ok) begin
          enter    = 1'b1;
          enter_st = ST_ID;
        end
      end
      ST_ID: begin
        if (done_ok) begin
          br_d     = dec_branch;
          mrd_d    = dec_mem_read;
          mwr_d    = dec_mem_write;
          rw_d     = dec_reg_write;
          enter    = 1'b1;
          enter_st = dec_jump ? ST_JU : ST_EX;
        end
      end
      ST_EX: begin
        if (done_ok) begin
          if (br_q) begin
            enter    = 1'b1;
            enter_st = ST_BR;
          end else if (mrd_q || mwr_q) begin
            enter    = 1'b1;
            enter_st = ST_MEM;
          end else if (rw_q) begin
            enter    = 1'b1;
            enter_st = ST_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_MEM: begin
        if (done_ok) begin
          if (mrd_q && rw_q) begin
            enter    = 1'b1;
            enter_st = ST_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_BR: begin
        if (done_ok) begin
          tgt_d   = target_pc;
          redir_d = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_JU: begin
        if (done_ok) begin
          tgt_d   = target_pc;
          redir_d = 1'b1;
          if (rw_q) begin
            enter    = 1'b1;
            enter_st = ST_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_WB: retire = done_ok;
      default: ;
    endcase

    // A valid done always beats the timeout on the same cycle.
    if (waiting && !done_ok) begin
      if (wait_q == TO_W'(TIMEOUT - 1)) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if (retire) begin
      pc_d    = redir_d ? tgt_d : pc_q + ADDR_W'(4);
      count_d = count_q + 32'd1;
      redir_d = 1'b0;
      if (run) begin
        enter    = 1'b1;
        enter_st = ST_IF;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (enter) begin
      state_d = enter_st;
      first_d = 1'b1;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      wait_q  <= '0;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      redir_q <= 1'b0;
      count_q <= '0;
      fault_q <= 1'b0;
      br_q    <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      redir_q <= redir_d;
      count_q <= count_d;
      fault_q <= fault_d;
      br_q    <= br_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      rw_q    <= rw_d;
    end
  end

  assign if_en  = first_q && (state_q == ST_IF);
  assign id_en  = first_q && (state_q == ST_ID);
  assign ex_en  = first_q && (state_q == ST_EX);
  assign mem_en = first_q && (state_q == ST_MEM);
  assign wb_en  = first_q && (state_q == ST_WB);
  assign ju_en  = first_q && (state_q == ST_JU);
  assign br_en  = first_q && (state_q == ST_BR);

  assign stage = {state_q == ST_BR, state_q == ST_JU, state_q == ST_WB, state_q == ST_MEM,
                  state_q == ST_EX, state_q == ST_ID, state_q == ST_IF};

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: an instruction-level model plans every cycle's stimulus and
// expected outputs up front, then one loop drives and compares cycle by cycle.
module tb_stage_sequencer;
  localparam int AW = 32;
  localparam int TMO = 255;
  localparam logic [AW-1:0] RST_PC = '0;

  localparam int U_IF = 0, U_ID = 1, U_EX = 2, U_MEM = 3, U_WB = 4, U_JU = 5, U_BR = 6;
  localparam int C_RW = 0, C_MW = 1, C_MR = 2, C_BR = 3, C_JMP = 4;

  typedef struct packed {
    logic          run;
    logic [6:0]    done;
    logic [4:0]    cls;
    logic [AW-1:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [6:0]    stg;
    logic [6:0]    en;
    logic [AW-1:0] pc;
    logic [31:0]   cnt;
    logic          busy;
    logic          fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic if_done = 1'b0, id_done = 1'b0, ex_done = 1'b0, mem_done = 1'b0;
  logic wb_done = 1'b0, br_done = 1'b0, ju_done = 1'b0;
  logic dec_jump = 1'b0, dec_branch = 1'b0, dec_mem_read = 1'b0;
  logic dec_mem_write = 1'b0, dec_reg_write = 1'b0;
  logic [AW-1:0] target_pc = '0;
  logic if_en, id_en, ex_en, mem_en, wb_en, br_en, ju_en;
  logic [AW-1:0] pc;
  logic [6:0] stage;
  logic busy, fault;
  logic [31:0] instr_count;
  logic [6:0] enVec;

  int checks = 0;
  int errors = 0;
  int curIdx = 0;
  int phase = 0;

  stim_t stimQ[$];
  exp_t expQ[$];
  int pathQ[$];
  logic [AW-1:0] mPc;
  logic [31:0] mCnt;

  int pinBrIdx = -1, pinBr2Idx = -1, pinJalIdx = -1, pinJalBrIdx = -1;
  int pinIdleIdx = -1, pinStallIdx = -1, pinFaultIdx = -1;

  stage_sequencer #(
    .ADDR_W(AW), .RESET_PC(RST_PC), .TIMEOUT(TMO), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .br_en(br_en), .ju_en(ju_en),
    .if_done(if_done), .id_done(id_done), .ex_done(ex_done), .mem_done(mem_done),
    .wb_done(wb_done), .br_done(br_done), .ju_done(ju_done),
    .dec_jump(dec_jump), .dec_branch(dec_branch), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .target_pc(target_pc), .pc(pc), .stage(stage), .busy(busy),
    .instr_count(instr_count), .fault(fault)
  );

  assign enVec = {br_en, ju_en, wb_en, mem_en, ex_en, id_en, if_en};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s @%0d: got 0x%0h want 0x%0h", name, curIdx, act, req);
    end
  endtask

  // The order of units an instruction visits follows directly from its decode class.
  task automatic fillPath(input logic [4:0] c);
    pathQ = {};
    pathQ.push_back(U_IF);
    pathQ.push_back(U_ID);
    if (c[C_JMP]) begin
      pathQ.push_back(U_JU);
      if (c[C_RW]) pathQ.push_back(U_WB);
    end else begin
      pathQ.push_back(U_EX);
      if (c[C_BR]) pathQ.push_back(U_BR);
      else if (c[C_MR] || c[C_MW]) begin
        pathQ.push_back(U_MEM);
        if (c[C_MR] && c[C_RW]) pathQ.push_back(U_WB);
      end else if (c[C_RW]) pathQ.push_back(U_WB);
    end
  endtask

  task automatic planStage(input int unit, input int dur, input logic [4:0] c,
                           input logic [AW-1:0] t, input logic runEnd,
                           input logic finalStage, input logic spurious, input logic finishes);
    for (int off = 0; off < dur; off++) begin
      stim_t s;
      exp_t e;
      s.run  = 1'($urandom_range(0, 1));
      s.done = 7'($urandom) & ~(7'd1 << unit);
      s.cls  = 5'($urandom);
      s.tgt  = $urandom;
      if (spurious && off == 0) s.done[unit] = 1'b1;
      if (finishes && off == dur - 1) begin
        s.done[unit] = 1'b1;
        if (unit == U_ID) s.cls = c;
        if (unit == U_BR || unit == U_JU) s.tgt = t;
        if (finalStage) s.run = runEnd;
      end
      e.stg   = 7'd1 << unit;
      e.en    = (off == 0) ? (7'd1 << unit) : 7'd0;
      e.pc    = mPc;
      e.cnt   = mCnt;
      e.busy  = 1'b1;
      e.fault = 1'b0;
      stimQ.push_back(s);
      expQ.push_back(e);
    end
  endtask

  task automatic planIdle(input int n);
    for (int k = 0; k < n; k++) begin
      stim_t s;
      exp_t e;
      s.run  = (k == n - 1);
      s.done = 7'($urandom);
      s.cls  = 5'($urandom);
      s.tgt  = $urandom;
      e.stg  = '0;
      e.en   = '0;
      e.pc   = mPc;
      e.cnt  = mCnt;
      e.busy = 1'b0;
      e.fault = 1'b0;
      stimQ.push_back(s);
      expQ.push_back(e);
    end
  endtask

  task automatic planInstr(input logic [4:0] c, input logic [AW-1:0] t, input logic runEnd,
                           input logic spurious, input int idleAfter, input int durMax,
                           input int exDur);
    bit redirect;
    int dur;
    redirect = 1'b0;
    fillPath(c);
    foreach (pathQ[k]) begin
      dur = (pathQ[k] == U_EX && exDur > 0) ? exDur : $urandom_range(2, durMax);
      if (pathQ[k] == U_BR || pathQ[k] == U_JU) redirect = 1'b1;
      planStage(pathQ[k], dur, c, t, runEnd, k == pathQ.size() - 1, spurious, 1'b1);
    end
    mPc  = redirect ? t : mPc + 32'd4;
    mCnt = mCnt + 32'd1;
    if (!runEnd) planIdle(idleAfter);
  endtask

  // Plans an instruction whose given unit never answers; fault cycles follow if requested.
  task automatic planStuck(input logic [4:0] c, input int unit, input int waitCyc,
                           input int faultCyc);
    bit stop;
    stop = 1'b0;
    fillPath(c);
    foreach (pathQ[k]) begin
      if (!stop) begin
        if (pathQ[k] == unit) begin
          planStage(unit, waitCyc, c, '0, 1'b1, 1'b0, 1'b1, 1'b0);
          stop = 1'b1;
        end else begin
          planStage(pathQ[k], 2, c, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
      end
    end
    for (int k = 0; k < faultCyc; k++) begin
      stim_t s;
      exp_t e;
      s.run  = 1'b1;
      s.done = 7'($urandom);
      s.done[unit] = 1'b1;
      s.cls  = 5'($urandom);
      s.tgt  = $urandom;
      e.stg  = '0;
      e.en   = '0;
      e.pc   = mPc;
      e.cnt  = mCnt;
      e.busy = 1'b0;
      e.fault = 1'b1;
      stimQ.push_back(s);
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    run           = s.run;
    if_done       = s.done[U_IF];
    id_done       = s.done[U_ID];
    ex_done       = s.done[U_EX];
    mem_done      = s.done[U_MEM];
    wb_done       = s.done[U_WB];
    ju_done       = s.done[U_JU];
    br_done       = s.done[U_BR];
    dec_jump      = s.cls[C_JMP];
    dec_branch    = s.cls[C_BR];
    dec_mem_read  = s.cls[C_MR];
    dec_mem_write = s.cls[C_MW];
    dec_reg_write = s.cls[C_RW];
    target_pc     = s.tgt;
  endtask

  task automatic checkOutput(input int i, input exp_t e);
    curIdx = i;
    checkVal("stage", 64'(stage), 64'(e.stg));
    checkVal("enables", 64'(enVec), 64'(e.en));
    checkVal("pc", 64'(pc), 64'(e.pc));
    checkVal("instr_count", 64'(instr_count), 64'(e.cnt));
    checkVal("busy", 64'(busy), 64'(e.busy));
    checkVal("fault", 64'(fault), 64'(e.fault));
  endtask

  task automatic pinChecks(input int i);
    if (i == 1) checkVal("pin_if_en_c1", 64'(if_en), 64'd1);
    if (i == 3) checkVal("pin_id_en_c3", 64'(id_en), 64'd1);
    if (i == 5) checkVal("pin_ex_en_c5", 64'(ex_en), 64'd1);
    if (i == 7) checkVal("pin_wb_en_c7", 64'(wb_en), 64'd1);
    if (i == 9) begin
      checkVal("pin_pc_c9", 64'(pc), 64'h4);
      checkVal("pin_cnt_c9", 64'(instr_count), 64'd1);
      checkVal("pin_if_en_c9", 64'(if_en), 64'd1);
      checkVal("pin_model_pc_c9", 64'(expQ[9].pc), 64'h4);
    end
    if (i == pinBrIdx) checkVal("pin_branch_taken_pc", 64'(pc), 64'h40);
    if (i == pinBr2Idx) checkVal("pin_branch_fall_pc", 64'(pc), 64'h44);
    if (i == pinJalIdx) checkVal("pin_jal_pc", 64'(pc), 64'h100);
    if (i == pinJalBrIdx) checkVal("pin_jal_branch_pc", 64'(pc), 64'h200);
    if (i == pinIdleIdx) begin
      checkVal("pin_idle_pc", 64'(pc), 64'h204);
      checkVal("pin_idle_cnt", 64'(instr_count), 64'd9);
      checkVal("pin_idle_busy", 64'(busy), 64'd0);
    end
    if (i == pinStallIdx) begin
      checkVal("pin_stall_pc", 64'(pc), 64'h208);
      checkVal("pin_stall_cnt", 64'(instr_count), 64'd10);
    end
    if (i == pinFaultIdx) begin
      checkVal("pin_fault_flag", 64'(fault), 64'd1);
      checkVal("pin_fault_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < stimQ.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(stimQ[i]);
      @(negedge clk);
      checkOutput(i, expQ[i]);
      if (phase == 1) pinChecks(i);
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_stage"}, 64'(stage), 64'd0);
    checkVal({tag, "_en"}, 64'(enVec), 64'd0);
    checkVal({tag, "_busy"}, 64'(busy), 64'd0);
    checkVal({tag, "_pc"}, 64'(pc), 64'(RST_PC));
    checkVal({tag, "_cnt"}, 64'(instr_count), 64'd0);
    checkVal({tag, "_fault"}, 64'(fault), 64'd0);
  endtask

  task automatic quietInputs();
    stim_t s;
    s = '0;
    applyStimulus(s);
  endtask

  initial begin
    mPc  = RST_PC;
    mCnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Directed instructions, then stall, random traffic and finally a hung unit.
    planIdle(1);
    planInstr(5'b00001, '0, 1'b1, 1'b0, 1, 2, 0);
    planInstr(5'b00101, '0, 1'b1, 1'b1, 1, 3, 0);
    planInstr(5'b00010, '0, 1'b1, 1'b0, 1, 3, 0);
    planInstr(5'b00001, '0, 1'b1, 1'b0, 1, 3, 0);
    planInstr(5'b01000, 32'h40, 1'b1, 1'b0, 1, 3, 0);
    pinBrIdx = stimQ.size();
    planInstr(5'b01000, 32'h44, 1'b1, 1'b0, 1, 3, 0);
    pinBr2Idx = stimQ.size();
    planInstr(5'b10001, 32'h100, 1'b1, 1'b0, 1, 3, 0);
    pinJalIdx = stimQ.size();
    planInstr(5'b11001, 32'h200, 1'b1, 1'b0, 1, 3, 0);
    pinJalBrIdx = stimQ.size();
    planInstr(5'b00001, '0, 1'b0, 1'b1, 3, 3, 0);
    pinIdleIdx = stimQ.size() - 1;
    planInstr(5'b00000, '0, 1'b1, 1'b0, 1, 2, TMO);
    pinStallIdx = stimQ.size();
    for (int n = 0; n < 40; n++) begin
      planInstr(5'($urandom), $urandom, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(1, 3), 5, 0);
    end
    planStuck(5'b00001, U_EX, TMO, 20);
    pinFaultIdx = stimQ.size() - 10;

    phase = 1;
    runTable();

    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkReset("fault_clear");
    quietInputs();
    mPc  = RST_PC;
    mCnt = '0;
    stimQ = {};
    expQ = {};
    @(negedge clk);
    rst = 1'b0;

    // One retired instruction, then a load aborted by reset while in MEM.
    phase = 2;
    planIdle(1);
    planInstr(5'b00001, '0, 1'b1, 1'b0, 1, 3, 0);
    planStuck(5'b00101, U_MEM, 2, 0);
    runTable();

    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkReset("abort_mem");
    quietInputs();
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
